// File: rtl/pin_attempt_ctrl_pkg.sv
// Shared definitions for the PIN brute-force controller: state encoding,
// ASCII constants, the TX payload layout and the BCD-to-ASCII packing helper.
package pin_attempt_ctrl_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned DIGITS  = 4;
   localparam int unsigned PIN_W   = DIGIT_W * DIGITS;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned TX_W    = BYTE_W * DIGITS;

   localparam logic [STATE_W-1:0] ST_IDLE        = 3'd0;
   localparam logic [STATE_W-1:0] ST_WAIT_PROMPT = 3'd1;
   localparam logic [STATE_W-1:0] ST_SEND        = 3'd2;
   localparam logic [STATE_W-1:0] ST_WAIT_TX     = 3'd3;
   localparam logic [STATE_W-1:0] ST_WAIT_RESULT = 3'd4;
   localparam logic [STATE_W-1:0] ST_ADVANCE     = 3'd5;
   localparam logic [STATE_W-1:0] ST_FOUND       = 3'd6;
   localparam logic [STATE_W-1:0] ST_EXHAUSTED   = 3'd7;

   localparam logic [BYTE_W-1:0] ASCII_ZERO       = 8'h30;
   localparam logic [BYTE_W-1:0] DEF_PROMPT_CHAR  = 8'h3A;
   localparam logic [BYTE_W-1:0] DEF_INVALID_CHAR = 8'h69;

   localparam logic [PIN_W-1:0] PIN_MAX = 16'h9999;

   // Four ASCII digits as sent on the wire; d0 is the least significant lane.
   typedef struct packed {
      logic [BYTE_W-1:0] d3;
      logic [BYTE_W-1:0] d2;
      logic [BYTE_W-1:0] d1;
      logic [BYTE_W-1:0] d0;
   } tx_word_t;

   function automatic tx_word_t pin_to_ascii(input logic [PIN_W-1:0] pin);
      tx_word_t w;
      w.d0 = ASCII_ZERO + BYTE_W'(pin[3:0]);
      w.d1 = ASCII_ZERO + BYTE_W'(pin[7:4]);
      w.d2 = ASCII_ZERO + BYTE_W'(pin[11:8]);
      w.d3 = ASCII_ZERO + BYTE_W'(pin[15:12]);
      return w;
   endfunction

   // States in which the loop is not actively working an attempt.
   function automatic logic is_settled(input logic [STATE_W-1:0] st);
      return (st == ST_IDLE) || (st == ST_FOUND) || (st == ST_EXHAUSTED);
   endfunction

   // States that only reset can leave.
   function automatic logic is_terminal(input logic [STATE_W-1:0] st);
      return (st == ST_FOUND) || (st == ST_EXHAUSTED);
   endfunction

endpackage

// File: rtl/pin_attempt_ctrl_bcd_pin_counter.sv
// Four-digit BCD candidate counter, 0000..9999, ripple carry between digits.
// Holds at 9999; the controller decides what happens at the top.
module bcd_pin_counter
   import pin_attempt_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [PIN_W-1:0] value,
   output logic             at_max
);

   logic [PIN_W-1:0] value_nxt;
   logic             carry;

   // Each digit rolls 9->0 and passes the carry up; a non-9 digit absorbs it.
   always_comb begin
      value_nxt = value;
      carry     = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (carry) begin
            if (value[d*DIGIT_W +: DIGIT_W] == DIGIT_W'(9)) begin
               value_nxt[d*DIGIT_W +: DIGIT_W] = '0;
            end else begin
               value_nxt[d*DIGIT_W +: DIGIT_W] = value[d*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
               carry = 1'b0;
            end
         end
      end
   end

   assign at_max = (value == PIN_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (inc && !at_max) begin
         value <= value_nxt;
      end
   end

endmodule

// File: rtl/pin_attempt_ctrl.sv
// PIN brute-force sequencer: waits for the target's prompt, sends the current
// BCD candidate as four ASCII digits, then advances on reject or latches on silence.
module pin_attempt_ctrl
   import pin_attempt_ctrl_pkg::*;
#(
   parameter logic [7:0]  PROMPT_CHAR    = DEF_PROMPT_CHAR,
   parameter logic [7:0]  INVALID_CHAR   = DEF_INVALID_CHAR,
   parameter int unsigned SILENCE_CYCLES = 12_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   output logic             tx_start,
   output logic [TX_W-1:0]  tx_data,
   input  logic             tx_done,
   output logic [PIN_W-1:0] pin_bcd,
   output logic             busy,
   output logic             found,
   output logic [PIN_W-1:0] found_pin,
   output logic             exhausted
);

   localparam int unsigned     CNT_W        = $clog2(SILENCE_CYCLES);
   localparam logic [CNT_W-1:0] SILENCE_LAST = CNT_W'(SILENCE_CYCLES - 1);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_nxt;
   logic [CNT_W-1:0]   silence_cnt;
   logic               pin_at_max;
   logic               is_prompt_c;
   logic               is_invalid_c;
   logic               silence_done_c;
   logic               pin_inc_c;
   logic               tx_start_nxt_c;

   assign is_prompt_c    = rx_valid && (rx_data == PROMPT_CHAR);
   assign is_invalid_c   = rx_valid && (rx_data == INVALID_CHAR);
   assign silence_done_c = !rx_valid && (silence_cnt == SILENCE_LAST);

   bcd_pin_counter u_pin_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (pin_inc_c),
      .value  (pin_bcd),
      .at_max (pin_at_max)
   );

   // Next-state and strobe decode; abort wins over any non-terminal move.
   always_comb begin
      state_nxt      = state;
      pin_inc_c      = 1'b0;
      tx_start_nxt_c = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_WAIT_PROMPT;
         end
         ST_WAIT_PROMPT: begin
            if (is_prompt_c) state_nxt = ST_SEND;
         end
         ST_SEND: begin
            state_nxt = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            if (tx_done) state_nxt = ST_WAIT_RESULT;
         end
         ST_WAIT_RESULT: begin
            // A reject beats silence expiry; a bare prompt means resend the same PIN.
            if (is_invalid_c) begin
               state_nxt = ST_ADVANCE;
            end else if (is_prompt_c) begin
               state_nxt = ST_SEND;
            end else if (silence_done_c) begin
               state_nxt = ST_FOUND;
            end
         end
         ST_ADVANCE: begin
            state_nxt = pin_at_max ? ST_EXHAUSTED : ST_WAIT_PROMPT;
         end
         ST_FOUND: begin
            state_nxt = ST_FOUND;
         end
         ST_EXHAUSTED: begin
            state_nxt = ST_EXHAUSTED;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (abort && !is_terminal(state)) begin
         state_nxt = ST_IDLE;
      end

      pin_inc_c      = (state == ST_ADVANCE) && (state_nxt == ST_WAIT_PROMPT);
      tx_start_nxt_c = (state == ST_SEND) && (state_nxt == ST_WAIT_TX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Silence timer: zero outside WAIT_RESULT and on any byte, saturates at the last count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         silence_cnt <= '0;
      end else if ((state != ST_WAIT_RESULT) || rx_valid) begin
         silence_cnt <= '0;
      end else if (silence_cnt != SILENCE_LAST) begin
         silence_cnt <= silence_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_start  <= 1'b0;
         tx_data   <= pin_to_ascii('0);
         busy      <= 1'b0;
         found     <= 1'b0;
         found_pin <= '0;
         exhausted <= 1'b0;
      end else begin
         tx_start  <= tx_start_nxt_c;
         tx_data   <= pin_to_ascii(pin_bcd);
         busy      <= !is_settled(state_nxt);
         found     <= (state_nxt == ST_FOUND);
         exhausted <= (state_nxt == ST_EXHAUSTED);
         if ((state != ST_FOUND) && (state_nxt == ST_FOUND)) begin
            found_pin <= pin_bcd;
         end
      end
   end

endmodule
